// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: receiver states and parity modes.
package uart_rx_buffered_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // data_xor is the XOR of all data bits, p the received parity bit.
    function automatic logic parity_ok(input int mode, input logic data_xor, input logic p);
        if (mode == PARITY_ODD) return data_xor ^ p;
        return !(data_xor ^ p);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO; pointers carry one extra bit for full/empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with configurable frame format, sticky error flags and a receive FIFO.
module uart_rx_buffered #(
    parameter int BAUD_DIV    = 20,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_err,
    input  logic                          err_clr
);

    import uart_rx_buffered_pkg::*;

    localparam int CW = $clog2(BAUD_DIV);
    localparam int IW = 4;
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    rx_state_e              state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;

    logic stop_sample, commit, push_req, pop, full, empty;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) sync <= '1;
        else             sync <= {sync[SYNC_STAGES-2:0], rxd};
    end
    assign rxs = sync[SYNC_STAGES-1];

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (!rxs) begin
                    state <= ST_START;
                    cnt   <= HALF_RELOAD;
                end
                // Mid-bit recheck of the start bit rejects short glitches.
                ST_START: if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (rxs) state <= ST_IDLE;
                    else begin
                        state   <= ST_DATA;
                        cnt     <= BIT_RELOAD;
                        idx     <= '0;
                        par_bad <= 1'b0;
                    end
                ST_DATA: if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        cnt   <= BIT_RELOAD;
                        if (idx == IW'(DATA_BITS - 1)) begin
                            idx   <= '0;
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                ST_PARITY: if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        par_bad <= !parity_ok(PARITY, ^shreg, rxs);
                        cnt     <= BIT_RELOAD;
                        state   <= ST_STOP;
                    end
                ST_STOP: if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!rxs) state <= ST_BREAK;
                    else if (idx == IW'(STOP_BITS - 1)) state <= ST_IDLE;
                    else begin
                        idx <= idx + 1'b1;
                        cnt <= BIT_RELOAD;
                    end
                // Hold off new starts until the line returns to idle.
                ST_BREAK: if (rxs) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign stop_sample = (state == ST_STOP) && (cnt == '0);
    assign commit      = stop_sample && rxs && (idx == IW'(STOP_BITS - 1));
    assign push_req    = commit && !par_bad;
    assign pop         = rx_valid && rx_ready;
    assign rx_valid    = !empty;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (commit && par_bad)         parity_err  <= 1'b1;
            else if (err_clr)              parity_err  <= 1'b0;
            if (stop_sample && !rxs)       frame_err   <= 1'b1;
            else if (err_clr)              frame_err   <= 1'b0;
            if (push_req && full && !pop)  overrun_err <= 1'b1;
            else if (err_clr)              overrun_err <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .push  (push_req),
        .din   (shreg),
        .pop   (pop),
        .dout  (rx_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule
